// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder memory target.
// Imported by the responder FSM and by its storage array.
package mem_responder_types;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

  localparam int MAX_LATENCY    = 15;
  localparam int MEM_WORD_BYTES = 4;
  localparam int CNT_WIDTH      = 4;

  // Everything captured from the initiator at acceptance except the word index,
  // whose width depends on the array depth.
  typedef struct packed {
    logic                      is_write;
    logic                      err;
    logic [MEM_WORD_BYTES-1:0] be;
    logic [31:0]               wdata;
  } req_t;

  // Value loaded into the latency counter at acceptance.
  function automatic logic [CNT_WIDTH-1:0] initial_count(input int latency);
    return CNT_WIDTH'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array with per-byte write enables and a registered read port,
// written so synthesis can map it onto block RAM.
module mem_array
  import mem_responder_types::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [MEM_WORD_BYTES-1:0] be_i,
  input  logic [31:0]               wdata_i,
  output logic [31:0]               rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // NOTE: the storage and its read register take no reset; a reset term would
  // stop the array from mapping onto block RAM, and contents must survive reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < MEM_WORD_BYTES; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Responder side of the mem_read/mem_write/mem_resp handshake: accepts one request,
// waits a fixed number of edges, then completes it against a byte-enabled array.
module mem_responder
  import mem_responder_types::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [MEM_WORD_BYTES-1:0] mem_byte_enable,
  input  logic [31:0]               mem_address,
  input  logic [31:0]               mem_wdata,
  output logic                      mem_resp,
  output logic [31:0]               mem_rdata,
  output logic                      mem_err
);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $fatal(1, "mem_responder: LATENCY must be within 1..15");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
    $fatal(1, "mem_responder: ADDR_WIDTH must be within 1..29");
  end

  localparam logic [CNT_WIDTH-1:0] LOAD_COUNT = initial_count(LATENCY);

  mem_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  req_t                  req_q, req_d;
  logic                  rdata_zero_q, rdata_zero_d;

  logic                  req_valid;
  req_t                  in_req;
  req_t                  eff_req;
  logic [ADDR_WIDTH-1:0] in_idx, eff_idx;
  logic                  enter_resp;
  logic                  ram_we, ram_re;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^mem_address[1:0];

  assign req_valid = mem_read | mem_write;
  assign in_idx    = mem_address[ADDR_WIDTH+1:2];
  assign in_req    = '{
    is_write: mem_write & ~mem_read,
    err:      (|mem_address[31:ADDR_WIDTH+2]) | (mem_read & mem_write),
    be:       mem_byte_enable,
    wdata:    mem_wdata
  };

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = in_idx;
          req_d   = in_req;
          count_d = LOAD_COUNT;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        count_d = count_q - CNT_WIDTH'(1);
        if (!req_valid) begin
          state_d = IDLE;
        end else if (count_q == CNT_WIDTH'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With LATENCY=1 the accepting edge is also the edge entering RESP, so the
  // array must see the live request rather than the not-yet-latched copy.
  assign eff_req    = (state_q == IDLE) ? in_req : req_q;
  assign eff_idx    = (state_q == IDLE) ? in_idx : idx_q;
  assign enter_resp = rst_n && (state_q != RESP) && (state_d == RESP);
  assign ram_we     = enter_resp & eff_req.is_write & ~eff_req.err;
  assign ram_re     = enter_resp & ~eff_req.is_write & ~eff_req.err;

  always_comb begin
    rdata_zero_d = rdata_zero_q;
    if (enter_resp && eff_req.err) begin
      rdata_zero_d = 1'b1;
    end else if (ram_re) begin
      rdata_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      idx_q        <= '0;
      req_q        <= '0;
      rdata_zero_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      req_q        <= req_d;
      rdata_zero_q <= rdata_zero_d;
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem_array (
    .clk    (clk),
    .we_i   (ram_we),
    .re_i   (ram_re),
    .addr_i (eff_idx),
    .be_i   (eff_req.be),
    .wdata_i(eff_req.wdata),
    .rdata_o(ram_rdata)
  );

  // Error responses and the post-reset state present zero instead of the
  // array's last read word, which is otherwise held between responses.
  assign mem_resp  = (state_q == RESP);
  assign mem_err   = (state_q == RESP) & req_q.err;
  assign mem_rdata = rdata_zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances (LATENCY 1, 2, 4, 5) driven by directed
// transactions, checked every cycle against a word-level reference memory.
module tb_mem_responder;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 4 : 5;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd    [4];
  logic        wr    [4];
  logic [3:0]  be    [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic        resp  [4];
  logic        err   [4];
  logic [31:0] rdata [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   (lat_of(g))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mem_read       (rd[g]),
      .mem_write      (wr[g]),
      .mem_byte_enable(be[g]),
      .mem_address    (addr[g]),
      .mem_wdata      (wdata[g]),
      .mem_resp       (resp[g]),
      .mem_rdata      (rdata[g]),
      .mem_err        (err[g])
    );
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 0;

  logic [31:0] model_mem  [4][1024];
  int          exp_resp_at[4];
  logic [31:0] pend_rdata [4];
  bit          pend_err   [4];
  bit          pend_keep  [4];
  logic [31:0] hold_rdata [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        bit exp_r;
        exp_r = (exp_resp_at[k] == cyc);
        if (exp_r && !pend_keep[k]) hold_rdata[k] = pend_rdata[k];
        check($sformatf("resp_k%0d_c%0d", k, cyc), {31'b0, resp[k]}, {31'b0, exp_r});
        check($sformatf("err_k%0d_c%0d", k, cyc), {31'b0, err[k]}, {31'b0, exp_r && pend_err[k]});
        check($sformatf("rdata_k%0d_c%0d", k, cyc), rdata[k], hold_rdata[k]);
      end
    end
  end

  // One complete transaction; returns in the response cycle. With keep=1 the
  // request stays asserted so the next call forms a back-to-back request.
  task automatic txn(input int k, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input bit keep = 0, input bit change = 0);
    int acc;
    int l;
    bit e;
    l = lat_of(k);
    @(negedge clk);
    rd[k] = r; wr[k] = w; addr[k] = a; wdata[k] = d; be[k] = b;
    @(posedge clk);
    #1;
    acc = cyc;
    e = (a[31:12] != 20'd0) || (r && w);
    pend_err[k]   = e;
    pend_keep[k]  = !e && w;
    pend_rdata[k] = (e || w) ? 32'd0 : model_mem[k][a[11:2]];
    exp_resp_at[k] = acc + l - 1;
    if (change) begin
      addr[k] = a ^ 32'h4; wdata[k] = ~d; be[k] = ~b;
    end
    repeat (l - 1) @(posedge clk);
    @(negedge clk);
    if (w && !r && !e) begin
      for (int i = 0; i < 4; i++)
        if (b[i]) model_mem[k][a[11:2]][8*i +: 8] = d[8*i +: 8];
    end
    if (!keep) begin
      rd[k] = 1'b0; wr[k] = 1'b0;
    end
  endtask

  // Write that is cut off in WAIT, by dropping the request or by reset.
  task automatic abort_write(input int k, input logic [31:0] a, input logic [31:0] d,
                             input bit use_reset);
    @(negedge clk);
    wr[k] = 1'b1; addr[k] = a; wdata[k] = d; be[k] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    if (use_reset) rst_n = 1'b0;
    else wr[k] = 1'b0;
    @(posedge clk);
    #1;
    if (use_reset) begin
      for (int j = 0; j < 4; j++) begin
        hold_rdata[j] = 32'd0; exp_resp_at[j] = -1;
      end
      check("reset_resp", {31'b0, resp[k]}, 32'd0);
      check("reset_err", {31'b0, err[k]}, 32'd0);
      check("reset_rdata", rdata[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; wr[k] = 1'b0;
    repeat (lat_of(k) + 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; be[k] = 4'h0; addr[k] = 32'd0; wdata[k] = 32'd0;
      exp_resp_at[k] = -1; hold_rdata[k] = 32'd0;
      pend_rdata[k] = 32'd0; pend_err[k] = 1'b0; pend_keep[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("init_resp", {31'b0, resp[k]}, 32'd0);
      check("init_err", {31'b0, err[k]}, 32'd0);
      check("init_rdata", rdata[k], 32'd0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;

    // LATENCY=2: basic, byte lanes, errors, misalignment, late input changes.
    txn(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    check("wr10_err", {31'b0, err[1]}, 32'd0);
    txn(1, 1, 0, 32'h10, 32'h0, 4'h0);
    check("rd10_lit", rdata[1], 32'hDEADBEEF);
    txn(1, 0, 1, 32'h20, 32'h11223344, 4'hF);
    txn(1, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101);
    txn(1, 1, 0, 32'h20, 32'h0, 4'h0);
    check("lanes_lit", rdata[1], 32'h11BB33DD);
    txn(1, 1, 0, 32'h1000, 32'h0, 4'h0);
    check("oor_err_lit", {31'b0, err[1]}, 32'd1);
    check("oor_rdata_lit", rdata[1], 32'd0);
    txn(1, 0, 1, 32'h4, 32'h55AA55AA, 4'hF);
    txn(1, 1, 1, 32'h4, 32'hFFFFFFFF, 4'hF);
    check("conflict_err_lit", {31'b0, err[1]}, 32'd1);
    txn(1, 1, 0, 32'h4, 32'h0, 4'h0);
    check("conflict_word_lit", rdata[1], 32'h55AA55AA);
    txn(1, 0, 1, 32'h10, 32'h0, 4'h0);
    txn(1, 1, 0, 32'h13, 32'h0, 4'h0);
    check("be0_misalign_lit", rdata[1], 32'hDEADBEEF);
    txn(1, 0, 1, 32'h8, 32'h08080808, 4'hF);
    txn(1, 0, 1, 32'hC, 32'h0C0C0C0C, 4'hF);
    txn(1, 1, 0, 32'h8, 32'h0, 4'h0, 0, 1);
    check("midchg_rd_lit", rdata[1], 32'h08080808);
    txn(1, 0, 1, 32'h8, 32'h88888888, 4'hF, 0, 1);
    txn(1, 1, 0, 32'hC, 32'h0, 4'h0);
    check("midchg_wr_other_lit", rdata[1], 32'h0C0C0C0C);
    txn(1, 1, 0, 32'h8, 32'h0, 4'h0);
    check("midchg_wr_lit", rdata[1], 32'h88888888);

    // LATENCY=1: back-to-back reads with one idle cycle between responses.
    txn(0, 0, 1, 32'h0, 32'h12345678, 4'hF);
    txn(0, 1, 0, 32'h0, 32'h0, 4'h0, 1);
    txn(0, 1, 0, 32'h0, 32'h0, 4'h0);
    check("lat1_rd_lit", rdata[0], 32'h12345678);
    txn(0, 0, 1, 32'hFFFFFFF0, 32'h1, 4'hF);
    check("lat1_oor_err_lit", {31'b0, err[0]}, 32'd1);

    // LATENCY=5: write held straight into a following read.
    txn(3, 0, 1, 32'h40, 32'hA5A5A5A5, 4'hF, 1);
    txn(3, 1, 0, 32'h40, 32'h0, 4'h0);
    check("lat5_rd_lit", rdata[3], 32'hA5A5A5A5);

    // LATENCY=4: abort by dropping the request, then abort by reset.
    txn(2, 0, 1, 32'h30, 32'hCAFEF00D, 4'hF);
    abort_write(2, 32'h30, 32'h0, 0);
    txn(2, 1, 0, 32'h30, 32'h0, 4'h0);
    check("abort_word_lit", rdata[2], 32'hCAFEF00D);
    abort_write(2, 32'h30, 32'h0, 1);
    txn(2, 1, 0, 32'h30, 32'h0, 4'h0);
    check("reset_word_lit", rdata[2], 32'hCAFEF00D);
    txn(1, 1, 0, 32'h10, 32'h0, 4'h0);
    check("reset_other_lit", rdata[1], 32'hDEADBEEF);

    repeat (6) @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
